// File: rtl/order_request_scheduler_if.sv
// order_request_scheduler_if: requester, order-book and completion signals of the scheduler
`ifndef STOCK_INDEX
`define STOCK_INDEX 2
`endif
`ifndef TOTAL_BITS
`define TOTAL_BITS 8
`endif
`ifndef QUANTITY_INDEX
`define QUANTITY_INDEX 7
`endif
`ifndef ORDER_INDEX
`define ORDER_INDEX 7
`endif
`ifndef NUM_STOCKS
`define NUM_STOCKS 4
`endif

interface order_request_scheduler_if #(
  parameter int NUM_REQ = 2
);
  localparam int SW = `STOCK_INDEX + 1;
  localparam int OW = `TOTAL_BITS;
  localparam int QW = `QUANTITY_INDEX + 1;
  localparam int IW = `ORDER_INDEX + 1;
  localparam int DW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*SW-1:0] req_stock;
  logic [NUM_REQ*OW-1:0] req_order;
  logic [NUM_REQ*QW-1:0] req_quantity;
  logic [NUM_REQ*3-1:0] req_type;
  logic [NUM_REQ*IW-1:0] req_order_id;
  logic book_start;
  logic [SW-1:0] book_stock;
  logic [OW-1:0] book_order;
  logic [QW-1:0] book_quantity;
  logic [2:0] book_request;
  logic [IW-1:0] book_order_id;
  logic book_busy;
  logic done_valid;
  logic [DW-1:0] done_id;
  logic [1:0] done_status;
  logic sched_busy;
  modport slave (
    input req_valid, req_stock, req_order, req_quantity, req_type, req_order_id, book_busy,
    output req_ready, book_start, book_stock, book_order, book_quantity, book_request, book_order_id,
    output done_valid, done_id, done_status, sched_busy
  );
  modport master (
    output req_valid, req_stock, req_order, req_quantity, req_type, req_order_id, book_busy,
    input req_ready, book_start, book_stock, book_order, book_quantity, book_request, book_order_id,
    input done_valid, done_id, done_status, sched_busy
  );
endinterface

// File: rtl/order_request_scheduler.sv
// order_request_scheduler: round-robin command scheduler feeding a single order-book wrapper
`ifndef STOCK_INDEX
`define STOCK_INDEX 2
`endif
`ifndef TOTAL_BITS
`define TOTAL_BITS 8
`endif
`ifndef QUANTITY_INDEX
`define QUANTITY_INDEX 7
`endif
`ifndef ORDER_INDEX
`define ORDER_INDEX 7
`endif
`ifndef NUM_STOCKS
`define NUM_STOCKS 4
`endif

module order_request_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input logic clk_in,
  input logic rst_n_in,
  order_request_scheduler_if.slave bus
);
  localparam int SW = `STOCK_INDEX + 1;
  localparam int OW = `TOTAL_BITS;
  localparam int QW = `QUANTITY_INDEX + 1;
  localparam int IW = `ORDER_INDEX + 1;
  localparam int DW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, REPORT} state_t;
  state_t state;
  logic [DW-1:0] ptr;
  logic [DW-1:0] grant_id;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel_stock;
  logic xfer;
  logic sel_bad;
  logic bad_stock;
  logic timed_out;
  // round-robin pick: walk backwards so the index closest to ptr wins
  always_comb begin
    grant = '0;
    grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        grant_id = DW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign bus.req_ready = (state == IDLE && rst_n_in) ? grant : '0;
  assign xfer = |(bus.req_valid & bus.req_ready);
  assign sel_stock = bus.req_stock[int'(grant_id)*SW +: SW];
  assign sel_bad = int'(sel_stock) >= `NUM_STOCKS;
  assign bad_stock = int'(bus.book_stock) >= `NUM_STOCKS;
  assign timed_out = cnt == CW'(TIMEOUT);
  assign bus.sched_busy = state != IDLE;
  // command FSM: latch on transfer, pulse the book, track busy with a timeout, report once
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.book_start <= 1'b0;
      bus.book_stock <= '0;
      bus.book_order <= '0;
      bus.book_quantity <= '0;
      bus.book_request <= '0;
      bus.book_order_id <= '0;
      bus.done_valid <= 1'b0;
      bus.done_id <= '0;
      bus.done_status <= 2'b00;
    end else begin
      bus.book_start <= 1'b0;
      bus.done_valid <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          state <= ISSUE;
          ptr <= (grant_id == DW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          bus.book_stock <= sel_stock;
          bus.book_order <= bus.req_order[int'(grant_id)*OW +: OW];
          bus.book_quantity <= bus.req_quantity[int'(grant_id)*QW +: QW];
          bus.book_request <= bus.req_type[int'(grant_id)*3 +: 3];
          bus.book_order_id <= bus.req_order_id[int'(grant_id)*IW +: IW];
          bus.done_id <= grant_id;
          bus.book_start <= !sel_bad;
        end
        ISSUE: begin
          state <= bad_stock ? REPORT : WAIT_BUSY;
          cnt <= '0;
          if (bad_stock) begin
            bus.done_valid <= 1'b1;
            bus.done_status <= 2'b01;
          end
        end
        WAIT_BUSY: if (bus.book_busy) begin
          state <= WAIT_DONE;
          cnt <= '0;
        end else if (timed_out) begin
          state <= REPORT;
          bus.done_valid <= 1'b1;
          bus.done_status <= 2'b10;
        end else cnt <= cnt + 1'b1;
        WAIT_DONE: if (!bus.book_busy) begin
          state <= REPORT;
          bus.done_valid <= 1'b1;
          bus.done_status <= 2'b00;
        end else if (timed_out) begin
          state <= REPORT;
          bus.done_valid <= 1'b1;
          bus.done_status <= 2'b10;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_order_request_scheduler.sv
// tb_order_request_scheduler: scoreboard bench with a busy-profile order-book model
module tb_order_request_scheduler;
  localparam int NR = 2;
  localparam int TO = 10;
  typedef struct {int id; int st; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfers = 0;
  int starts = 0;
  int t_xfer = 0;
  int cur_id = 0;
  int bcnt = 0;
  int mode = 0;
  exp_t exp_q[$];
  exp_t e;
  order_request_scheduler_if #(.NUM_REQ(NR)) bus ();
  order_request_scheduler #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // wrapper model: mode 0 busy 5 cycles from the edge after start, 1 stuck busy, 2 never busy
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bcnt <= 0;
    else if (bus.book_start) bcnt <= (mode == 1) ? 100000 : (mode == 2) ? 0 : 5;
    else if (bcnt > 0 && mode != 1) bcnt <= bcnt - 1;
  assign bus.book_busy = bcnt != 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [29:0] ops(input int r);
    return {3'd1, 8'(8'h30 + r), 8'(8'h50 + r), 3'(r + 1), 8'(8'hA0 + r)};
  endfunction
  function automatic logic [37:0] outs();
    return {bus.req_ready, bus.book_start, bus.done_valid, bus.done_status, bus.done_id, bus.sched_busy,
            bus.book_stock, bus.book_order, bus.book_quantity, bus.book_request, bus.book_order_id};
  endfunction
  task automatic set_fields(input int r, input int stock);
    bus.req_stock[r*3 +: 3] = 3'(stock);
    bus.req_order[r*8 +: 8] = 8'(8'h30 + r);
    bus.req_quantity[r*8 +: 8] = 8'(8'h50 + r);
    bus.req_type[r*3 +: 3] = 3'(r + 1);
    bus.req_order_id[r*8 +: 8] = 8'(8'hA0 + r);
  endtask
  task automatic issue(input logic [1:0] mask, input int n);
    int target;
    target = xfers + n;
    bus.req_valid = mask;
    for (int i = 0; i < 300 && xfers != target; i++) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    if (xfers != target) chk("xfer_timeout", 64'(xfers), 64'(target));
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask
  // monitor: grant, operand and completion checks against the scoreboard queue
  always @(negedge clk) if (rst_n) begin
    chk("ready_onehot", {63'd0, $onehot0(bus.req_ready) && !(bus.sched_busy && bus.req_ready != 0)}, 64'd1);
    if (|(bus.req_valid & bus.req_ready)) begin
      xfers++;
      t_xfer = cyc;
      cur_id = bus.req_ready[1] ? 1 : 0;
      if (exp_q.size() != 0) chk("grant", 64'(cur_id), 64'(exp_q[0].id));
    end
    if (bus.book_start) begin
      starts++;
      chk("book_ops", 64'({bus.book_stock, bus.book_order, bus.book_quantity, bus.book_request, bus.book_order_id}), 64'(ops(cur_id)));
    end
    if (bus.done_valid) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("done_id", 64'(bus.done_id), 64'(e.id));
        chk("done_status", 64'(bus.done_status), 64'(e.st));
        chk("latency", 64'(cyc - t_xfer), 64'(e.lat));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.req_valid = 2'b11;
    set_fields(0, 1);
    set_fields(1, 1);
    #1;
    chk("reset_outputs", 64'(outs()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{0, 0, 8});
    exp_q.push_back('{1, 0, 8});
    exp_q.push_back('{0, 0, 8});
    exp_q.push_back('{1, 0, 8});
    issue(2'b11, 4);
    drain();
    exp_q.push_back('{0, 0, 8});
    issue(2'b01, 1);
    drain();
    set_fields(1, 4);
    n = starts;
    exp_q.push_back('{1, 1, 2});
    issue(2'b10, 1);
    drain();
    chk("bad_no_start", 64'(starts), 64'(n));
    set_fields(1, 1);
    mode = 1;
    exp_q.push_back('{0, 2, TO + 4});
    issue(2'b01, 1);
    drain();
    mode = 0;
    exp_q.push_back('{1, 0, 8});
    issue(2'b10, 1);
    drain();
    mode = 2;
    exp_q.push_back('{0, 2, TO + 3});
    issue(2'b01, 1);
    drain();
    mode = 0;
    issue(2'b10, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_wait_done", {63'd0, bus.sched_busy}, 64'd1);
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("reset_midop_outputs", 64'(outs()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{0, 0, 8});
    rst_n = 1'b1;
    issue(2'b11, 1);
    drain();
    repeat (5) @(posedge clk);
    chk("start_count", 64'(starts), 64'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
